// File: rtl/load_store_unit_if.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit_if
//  Purpose  : Single-port data-memory bus between the load/store unit
//             (master) and the data memory (slave).
//  Revision : 1.0  initial release
// ============================================================================
interface load_store_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : load_store_unit
//  Purpose  : Memory stage after the ALU: one load or store per request on a
//             req/ready data-memory bus, load data sign/zero-extended.
//             Optional macro MISALIGN_TRAP_EN: trap misaligned H/W accesses
//             instead of silently aligning them.
//  Revision : 1.0  initial release
// ============================================================================
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  wire logic        clk,
    input  wire logic        resetn,
    input  wire logic        start,
    input  wire logic        is_store,
    input  wire logic [2:0]  funct3,
    input  wire logic [31:0] addr,
    input  wire logic [31:0] wdata,
    output logic             busy,
    output logic             done,
    output logic [31:0]      rdata,
    output logic             fault,
    output logic             misaligned,
    load_store_unit_if.master mem
);

    localparam int                 c_cnt_w = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam bit                 c_to_en = (TIMEOUT != 0);
    localparam logic [c_cnt_w-1:0] c_to_m1 = c_cnt_w'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_is_store;
    logic [1:0]         r_size;
    logic               r_uns;
    logic [1:0]         r_off;
    logic               r_fault;
    logic [c_cnt_w-1:0] r_cnt;

    logic        w_legal;
    logic        w_mis;
    logic [1:0]  w_off;
    logic [3:0]  w_strb;
    logic [31:0] w_wdata;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [31:0] w_load;
    logic        w_timeout;

    // Loads accept 000/001/010/100/101, stores only 000/001/010.
    assign w_legal = is_store ? (!funct3[2] && funct3[1:0] != 2'b11)
                              : (funct3[1:0] != 2'b11 && !(funct3[2] && funct3[1]));

`ifdef MISALIGN_TRAP_EN
    assign w_mis = (funct3[1:0] == 2'b01 && addr[0]) ||
                   (funct3[1:0] == 2'b10 && addr[1:0] != 2'b00);
`else
    assign w_mis = 1'b0;
`endif

    // Without trapping, misaligned halves/words are forced onto their natural boundary.
    always_comb begin
        w_off   = 2'b00;
        w_strb  = 4'b0000;
        w_wdata = wdata;
        case (funct3[1:0])
            2'b00: begin
                w_off   = addr[1:0];
                w_strb  = 4'b0001 << w_off;
                w_wdata = {4{wdata[7:0]}};
            end
            2'b01: begin
                w_off   = {addr[1], 1'b0};
                w_strb  = 4'b0011 << w_off;
                w_wdata = {2{wdata[15:0]}};
            end
            default: begin
                w_off  = 2'b00;
                w_strb = 4'b1111;
            end
        endcase
        if (!is_store) begin
            w_strb = 4'b0000;
        end
    end

    assign w_byte = mem.mem_rdata[{r_off, 3'b000} +: 8];
    assign w_half = r_off[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];

    always_comb begin
        case (r_size)
            2'b00:   w_load = {{24{!r_uns && w_byte[7]}}, w_byte};
            2'b01:   w_load = {{16{!r_uns && w_half[15]}}, w_half};
            default: w_load = mem.mem_rdata;
        endcase
    end

    assign w_timeout = c_to_en && !mem.mem_ready && (r_cnt == c_to_m1);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = (!w_legal || w_mis) ? ST_DONE : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (mem.mem_ready || w_timeout) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE:  w_state_nxt = ST_IDLE;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_is_store    <= 1'b0;
            r_size        <= 2'b00;
            r_uns         <= 1'b0;
            r_off         <= 2'b00;
            r_fault       <= 1'b0;
            r_cnt         <= '0;
            rdata         <= 32'h0;
            mem.mem_addr  <= 32'h0;
            mem.mem_wdata <= 32'h0;
            mem.mem_wstrb <= 4'b0000;
        end else begin
            if (r_state == ST_IDLE && start) begin
                r_is_store    <= is_store;
                r_size        <= funct3[1:0];
                r_uns         <= funct3[2];
                r_off         <= w_off;
                r_fault       <= !w_legal;
                r_cnt         <= '0;
                mem.mem_addr  <= {addr[31:2], 2'b00};
                mem.mem_wdata <= w_wdata;
                mem.mem_wstrb <= w_strb;
            end else if (r_state == ST_ACCESS) begin
                if (mem.mem_ready) begin
                    if (!r_is_store) begin
                        rdata <= w_load;
                    end
                end else if (w_timeout) begin
                    r_fault <= 1'b1;
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    logic r_mis;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_mis <= 1'b0;
        end else if (r_state == ST_IDLE && start) begin
            r_mis <= w_legal && w_mis;
        end
    end

    assign misaligned = done && r_mis;
`else
    assign misaligned = 1'b0;
`endif

    assign busy        = (r_state == ST_ACCESS);
    assign done        = (r_state == ST_DONE);
    assign fault       = done && r_fault;
    assign mem.mem_req = busy;
    assign mem.mem_we  = busy && r_is_store;

endmodule
`default_nettype wire

// File: tb/tb_load_store_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_load_store_unit
//  Purpose  : Self-checking bench for load_store_unit (TIMEOUT = 4) against a
//             transaction-level reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_load_store_unit;

    localparam int c_tmo = 4;

    typedef struct packed {
        logic [7:0]  lat;
        logic [7:0]  reqs;
        logic        fault;
        logic        mis;
        logic [31:0] rdata;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  strb;
        logic [31:0] wd;
        logic        stable;
        logic        ign_ok;
    } obs_t;

    logic        clk;
    logic        resetn;
    logic        start;
    logic        is_store;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        fault;
    logic        misaligned;

    int          n_cmp;
    int          n_fail;
    logic [31:0] exp_rdata;

    load_store_unit_if mem_if ();

    load_store_unit #(.TIMEOUT(c_tmo)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .start      (start),
        .is_store   (is_store),
        .funct3     (funct3),
        .addr       (addr),
        .wdata      (wdata),
        .busy       (busy),
        .done       (done),
        .rdata      (rdata),
        .fault      (fault),
        .misaligned (misaligned),
        .mem        (mem_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic string fmt(input obs_t o);
        return $sformatf("lat=%0d reqs=%0d fault=%0b mis=%0b rdata=%h addr=%h we=%0b strb=%b wd=%h stable=%0b ign=%0b",
                         o.lat, o.reqs, o.fault, o.mis, o.rdata, o.addr, o.we, o.strb, o.wd, o.stable, o.ign_ok);
    endfunction

    // Transaction-level expectation; also advances the held load result.
    function automatic obs_t model(input bit st, input logic [2:0] f3, input logic [31:0] a,
                                   input logic [31:0] wd, input logic [31:0] rw, input int waits);
        obs_t        e;
        bit          legal;
        bit          trap;
        int          sz;
        int          off;
        logic [31:0] mask;
        logic [31:0] v;
        logic [3:0]  lanes;
        e        = '0;
        e.stable = 1'b1;
        e.ign_ok = 1'b1;
        sz       = int'(f3[1:0]);
        legal    = st ? (f3 <= 3'd2) : (f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
        trap     = 1'b0;
`ifdef MISALIGN_TRAP_EN
        trap     = legal && ((sz == 1 && a[0]) || (sz == 2 && a[1:0] != 2'b00));
`endif
        e.fault  = !legal;
        e.mis    = trap;
        if (!legal || trap) begin
            e.lat = 8'd1;
        end else begin
            off   = (sz == 0) ? int'(a[1:0]) : (sz == 1) ? 2 * int'(a[1]) : 0;
            mask  = (sz == 0) ? 32'h0000_00FF : (sz == 1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
            lanes = (sz == 0) ? 4'h1 : (sz == 1) ? 4'h3 : 4'hF;
            e.addr = a & 32'hFFFF_FFFC;
            e.we   = st;
            if (st) begin
                e.strb = lanes << off;
                e.wd   = (sz == 0) ? wd[7:0] * 32'h0101_0101 : (sz == 1) ? wd[15:0] * 32'h0001_0001 : wd;
            end
            if (waits >= c_tmo) begin
                e.lat   = 8'(c_tmo + 1);
                e.reqs  = 8'(c_tmo);
                e.fault = 1'b1;
            end else begin
                e.lat  = 8'(waits + 2);
                e.reqs = 8'(waits + 1);
                if (!st) begin
                    v = (rw >> (8 * off)) & mask;
                    if (sz != 2 && !f3[2] && ((v & ((mask >> 1) + 32'd1)) != 0)) begin
                        v = v | ~mask;
                    end
                    exp_rdata = v;
                end
            end
        end
        e.rdata = exp_rdata;
        return e;
    endfunction

    // Issues one request and plays memory: mem_ready rises after `waits` request cycles.
    task automatic do_op(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] rw, input int waits,
                         input bit noisy, output obs_t o);
        int lat;
        bit busy_at_done;
        o        = '0;
        o.stable = 1'b1;
        @(negedge clk);
        start             = 1'b1;
        is_store          = st;
        funct3            = f3;
        addr              = a;
        wdata             = wd;
        mem_if.mem_ready  = 1'b0;
        mem_if.mem_rdata  = rw;
        lat               = 0;
        forever begin
            @(negedge clk);
            lat++;
            if (noisy) begin
                start    = 1'($urandom);
                is_store = 1'($urandom);
                funct3   = 3'($urandom);
                addr     = $urandom;
                wdata    = $urandom;
            end else begin
                start = 1'b0;
            end
            if (done === 1'b1 || lat >= 40) break;
            if (mem_if.mem_req === 1'b1) begin
                if (o.reqs == 0) begin
                    o.addr = mem_if.mem_addr;
                    o.we   = mem_if.mem_we;
                    o.strb = mem_if.mem_wstrb;
                    o.wd   = st ? mem_if.mem_wdata : 32'h0;
                end else if (o.addr !== mem_if.mem_addr || o.we !== mem_if.mem_we ||
                             o.strb !== mem_if.mem_wstrb || (st && o.wd !== mem_if.mem_wdata)) begin
                    o.stable = 1'b0;
                end
                if (busy !== 1'b1) o.stable = 1'b0;
                mem_if.mem_ready = (int'(o.reqs) == waits);
                o.reqs++;
            end else begin
                mem_if.mem_ready = 1'($urandom);
            end
        end
        o.lat        = 8'(lat);
        o.fault      = fault;
        o.mis        = misaligned;
        o.rdata      = rdata;
        busy_at_done = busy;
        // Memory ready and a fresh start during the done cycle must both be ignored.
        mem_if.mem_ready = 1'($urandom);
        start            = noisy;
        @(negedge clk);
        o.ign_ok         = (done === 1'b0 && mem_if.mem_req === 1'b0 && busy === 1'b0 && busy_at_done === 1'b0);
        start            = 1'b0;
        mem_if.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({busy, done, fault, misaligned, mem_if.mem_req, mem_if.mem_we} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got busy/done/fault/mis/req/we=%b want 000000",
                     {busy, done, fault, misaligned, mem_if.mem_req, mem_if.mem_we});
        end
        n_cmp++;
        if ({mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wstrb} !== 68'h0) begin
            n_fail++;
            $display("FAIL reset_bus: got addr=%h wdata=%h wstrb=%b want all zero",
                     mem_if.mem_addr, mem_if.mem_wdata, mem_if.mem_wstrb);
        end
        n_cmp++;
        if (rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h want 00000000", rdata);
        end
        resetn = 1'b1;
    endtask

    task automatic test_lw();
        obs_t o;
        obs_t e;
        e = model(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0);
        do_op(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEAD_BEEF, 0, 1'b0, o);
        n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL lw_model: got %s / want %s", fmt(o), fmt(e));
        end
        n_cmp++;
        if (o.rdata !== 32'hDEAD_BEEF || o.lat !== 8'd2 || o.addr !== 32'h100) begin
            n_fail++;
            $display("FAIL lw_direct: got rdata=%h lat=%0d addr=%h want deadbeef 2 00000100",
                     o.rdata, o.lat, o.addr);
        end
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s [3] = '{3'b000, 3'b100, 3'b101};
        logic [31:0] as  [3] = '{32'h103, 32'h103, 32'h102};
        logic [31:0] want[3] = '{32'hFFFF_FF80, 32'h0000_0080, 32'h0000_80FF};
        obs_t o;
        obs_t e;
        for (int i = 0; i < 3; i++) begin
            e = model(1'b0, f3s[i], as[i], 32'h0, 32'h80FF_0000, i);
            do_op(1'b0, f3s[i], as[i], 32'h0, 32'h80FF_0000, i, 1'b0, o);
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL ext_model[%0d]: got %s / want %s", i, fmt(o), fmt(e));
            end
            n_cmp++;
            if (o.rdata !== want[i]) begin
                n_fail++;
                $display("FAIL ext_direct[%0d]: got rdata=%h want %h", i, o.rdata, want[i]);
            end
        end
    endtask

    task automatic test_store_wait();
        obs_t o;
        obs_t e;
        e = model(1'b1, 3'b001, 32'h22, 32'h1234_ABCD, 32'h5555_5555, 3);
        do_op(1'b1, 3'b001, 32'h22, 32'h1234_ABCD, 32'h5555_5555, 3, 1'b1, o);
        n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL sh_model: got %s / want %s", fmt(o), fmt(e));
        end
        n_cmp++;
        if (o.we !== 1'b1 || o.strb !== 4'b1100 || o.wd !== 32'hABCD_ABCD || o.lat !== 8'd5 || o.stable !== 1'b1) begin
            n_fail++;
            $display("FAIL sh_direct: got we=%0b strb=%b wd=%h lat=%0d stable=%0b want 1 1100 abcdabcd 5 1",
                     o.we, o.strb, o.wd, o.lat, o.stable);
        end
    endtask

    task automatic test_timeout_illegal();
        obs_t o;
        obs_t e;
        e = model(1'b0, 3'b010, 32'h200, 32'h0, 32'h0BAD_F00D, 100);
        do_op(1'b0, 3'b010, 32'h200, 32'h0, 32'h0BAD_F00D, 100, 1'b0, o);
        n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL timeout_model: got %s / want %s", fmt(o), fmt(e));
        end
        n_cmp++;
        if (o.reqs !== 8'd4 || o.fault !== 1'b1 || o.lat !== 8'd5) begin
            n_fail++;
            $display("FAIL timeout_direct: got reqs=%0d fault=%0b lat=%0d want 4 1 5", o.reqs, o.fault, o.lat);
        end
        e = model(1'b0, 3'b011, 32'h300, 32'h0, 32'h1111_1111, 0);
        do_op(1'b0, 3'b011, 32'h300, 32'h0, 32'h1111_1111, 0, 1'b0, o);
        n_cmp++;
        if (o !== e || o.reqs !== 8'd0 || o.fault !== 1'b1 || o.lat !== 8'd1) begin
            n_fail++;
            $display("FAIL illegal_ld: got %s / want %s", fmt(o), fmt(e));
        end
        e = model(1'b1, 3'b100, 32'h300, 32'h0, 32'h1111_1111, 0);
        do_op(1'b1, 3'b100, 32'h300, 32'h0, 32'h1111_1111, 0, 1'b0, o);
        n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL illegal_st: got %s / want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_misaligned();
        obs_t o;
        obs_t e;
        e = model(1'b0, 3'b010, 32'h101, 32'h0, 32'h1122_3344, 0);
        do_op(1'b0, 3'b010, 32'h101, 32'h0, 32'h1122_3344, 0, 1'b0, o);
        n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL mis_model: got %s / want %s", fmt(o), fmt(e));
        end
        n_cmp++;
`ifdef MISALIGN_TRAP_EN
        if (o.mis !== 1'b1 || o.reqs !== 8'd0 || o.lat !== 8'd1) begin
            n_fail++;
            $display("FAIL mis_direct: got mis=%0b reqs=%0d lat=%0d want 1 0 1", o.mis, o.reqs, o.lat);
        end
`else
        if (o.mis !== 1'b0 || o.addr !== 32'h100 || o.rdata !== 32'h1122_3344) begin
            n_fail++;
            $display("FAIL mis_direct: got mis=%0b addr=%h rdata=%h want 0 00000100 11223344",
                     o.mis, o.addr, o.rdata);
        end
`endif
    endtask

    task automatic test_reset_mid_access();
        obs_t o;
        obs_t e;
        @(negedge clk);
        start            = 1'b1;
        is_store         = 1'b1;
        funct3           = 3'b010;
        addr             = 32'h400;
        wdata            = 32'hCAFE_0001;
        mem_if.mem_ready = 1'b0;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (mem_if.mem_req !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_access: got req=%0b busy=%0b want 1 1", mem_if.mem_req, busy);
        end
        resetn = 1'b0;
        #1;
        n_cmp++;
        if (mem_if.mem_req !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: got req=%0b busy=%0b done=%0b want 0 0 0", mem_if.mem_req, busy, done);
        end
        @(negedge clk);
        resetn    = 1'b1;
        exp_rdata = 32'h0;
        e = model(1'b0, 3'b001, 32'h406, 32'h0, 32'h7FFF_0001, 1);
        do_op(1'b0, 3'b001, 32'h406, 32'h0, 32'h7FFF_0001, 1, 1'b0, o);
        n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL post_reset_op: got %s / want %s", fmt(o), fmt(e));
        end
    endtask

    task automatic test_random();
        logic [2:0] legal_ld[5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        obs_t        o;
        obs_t        e;
        bit          st;
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] rw;
        int          waits;
        for (int i = 0; i < 60; i++) begin
            st = 1'($urandom);
            if ($urandom_range(0, 9) == 0) f3 = 3'($urandom);
            else f3 = st ? 3'($urandom_range(0, 2)) : legal_ld[$urandom_range(0, 4)];
            a     = $urandom;
            wd    = $urandom;
            rw    = $urandom;
            waits = $urandom_range(0, 5);
            e = model(st, f3, a, wd, rw, waits);
            do_op(st, f3, a, wd, rw, waits, 1'($urandom), o);
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL random[%0d] st=%0b f3=%b a=%h waits=%0d: got %s / want %s",
                         i, st, f3, a, waits, fmt(o), fmt(e));
            end
        end
    endtask

    initial begin
        n_cmp            = 0;
        n_fail           = 0;
        exp_rdata        = 32'h0;
        resetn           = 1'b0;
        start            = 1'b0;
        is_store         = 1'b0;
        funct3           = 3'b000;
        addr             = 32'h0;
        wdata            = 32'h0;
        mem_if.mem_ready = 1'b0;
        mem_if.mem_rdata = 32'h0;
        test_reset();
        test_lw();
        test_load_ext();
        test_store_wait();
        test_timeout_illegal();
        test_misaligned();
        test_reset_mid_access();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
